adcfifo_unpack: RTL and testbench
=================================

ADCFIFO_UNPACK -- requirements
Module: adcfifo_unpack

Interface
REQ-001 Parameter: COUNT_W, 32, width of num_samples_i and the internal remaining-sample counter.
REQ-002 clk_100mhz  in  1  single clock; all logic is on its rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 start_i  in  1  one-cycle pulse that begins an unpack run.
REQ-005 num_samples_i  in  COUNT_W  samples to deliver; sampled on start_i.
REQ-006 fifo_empty_i  in  1  ADC FIFO read-side empty flag.
REQ-007 fifo_data_i  in  8  ADC FIFO read data, valid the cycle after fifo_rd_en_o.
REQ-008 fifo_rd_en_o  out  1  ADC FIFO read strobe.
REQ-009 sample_o  out  10  unpacked ADC sample.
REQ-010 sample_or_o  out  1  out-of-range flag of the sample's source word.
REQ-011 sample_trig_o  out  1  trigger-status flag of the sample's source word.
REQ-012 sample_valid_o  out  1  sample outputs valid.
REQ-013 sample_ready_i  in  1  downstream accepts the sample.
REQ-014 busy_o  out  1  high from the cycle after an accepted start until done_o.
REQ-015 done_o  out  1  one-cycle pulse at the end of a run.

Function
REQ-016 The FIFO byte stream SHALL be MSB-first: 4 bytes form word W as {b0,b1,b2,b3}; W[31]=or, W[30]=trig, W[29:20]=s2, W[19:10]=s1, W[9:0]=s0.
REQ-017 The block SHALL implement the states IDLE, FETCH, EMIT and DONE.
REQ-018 IDLE: on start_i with num_samples_i>0, the block SHALL load remaining=num_samples_i, clear the byte count, and enter FETCH; with num_samples_i=0 it SHALL enter DONE without any FIFO read.
REQ-019 FETCH: fifo_rd_en_o SHALL be high only when fifo_empty_i=0 and reads issued for the current word are fewer than 4; it SHALL never be asserted while fifo_empty_i=1.
REQ-020 FETCH: on the cycle after each read, the block SHALL shift fifo_data_i into the word register (W <= {W[23:0],byte}).
REQ-021 After the 4th byte is captured, the block SHALL enter EMIT with sample index 0; word assembly latency is at least 5 cycles (4 reads plus 1 data latency).
REQ-022 EMIT: the block SHALL present s0, then s1, then s2, with sample_or_o=W[31] and sample_trig_o=W[30] for all three.
REQ-023 Handshake: a sample is accepted on a cycle where sample_valid_o=1 and sample_ready_i=1; while valid and not ready, all sample outputs SHALL hold stable.
REQ-024 Each acceptance SHALL decrement remaining by one; consecutive samples SHALL be accepted on back-to-back cycles while ready is held high.
REQ-025 When remaining reaches 0 on an acceptance, the block SHALL enter DONE and discard any unused samples of the current word.
REQ-026 When s2 is accepted with remaining>0, the block SHALL return to FETCH; no FIFO reads SHALL occur during EMIT.
REQ-027 DONE: done_o SHALL be high for exactly one cycle and busy_o SHALL go low in that cycle; the next state SHALL be IDLE.
REQ-028 start_i while busy_o=1 or in DONE SHALL be ignored.
REQ-029 A FIFO that runs empty mid-word SHALL stall FETCH with no reads issued and no bytes lost; fetching SHALL resume when fifo_empty_i falls.

Reset
REQ-030 With reset_n=0, the block SHALL asynchronously force IDLE, with fifo_rd_en_o, sample_valid_o, busy_o and done_o at 0, sample_o at 0, flags at 0, and the counters and word register at 0.
REQ-031 Reset asserted mid-run SHALL abort the run with no further reads; after release, the block SHALL wait in IDLE for a new start_i.

Verification
REQ-032 Bytes 0x40,0x20,0x0C,0x01, num_samples=3, ready=1 -> 4 reads; samples 0x001, 0x003, 0x002 with trig=1 and or=0; then a done_o pulse.
REQ-033 num_samples=4 with two words in the FIFO -> 8 reads; 4 samples; s1 and s2 of word 2 never presented; a done_o pulse.
REQ-034 sample_ready_i low for 5 cycles during s1 -> s1 held stable; no reads during the stall; remaining unchanged.
REQ-035 fifo_empty_i high after 2 bytes for 10 cycles -> fifo_rd_en_o stays 0; the word completes correctly once empty falls.
REQ-036 num_samples=0 -> no reads; a done_o pulse 1 cycle after start; a second start during busy is ignored.
REQ-037 reset_n pulsed low during EMIT -> all outputs 0 immediately; IDLE holds until the next start.

Source files
------------

// File: rtl/adcfifo_unpack.sv
// Reads 4-byte MSB-first words from an ADC FIFO and unpacks each into three
// 10-bit samples plus out-of-range/trigger flags, under a valid/ready handshake.
module adcfifo_unpack #(
    parameter int COUNT_W = 32
) (
    input  logic               clk_100mhz,
    input  logic               reset_n,
    input  logic               start_i,
    input  logic [COUNT_W-1:0] num_samples_i,
    input  logic               fifo_empty_i,
    input  logic [7:0]         fifo_data_i,
    output logic               fifo_rd_en_o,
    output logic [9:0]         sample_o,
    output logic               sample_or_o,
    output logic               sample_trig_o,
    output logic               sample_valid_o,
    input  logic               sample_ready_i,
    output logic               busy_o,
    output logic               done_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EMIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [COUNT_W-1:0] remaining_q, remaining_d;
    logic [2:0]         rd_cnt_q, rd_cnt_d;
    logic [2:0]         cap_cnt_q, cap_cnt_d;
    logic               rd_pend_q, rd_pend_d;
    logic [31:0]        word_q, word_d;
    logic [1:0]         idx_q, idx_d;
    logic               rd_en;

    // Read strobe is gated directly by the empty flag so it can never fire on an empty FIFO.
    assign rd_en = (state_q == ST_FETCH) && !fifo_empty_i && (rd_cnt_q < 3'd4);

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        rd_cnt_d    = rd_cnt_q;
        cap_cnt_d   = cap_cnt_q;
        rd_pend_d   = rd_pend_q;
        word_d      = word_q;
        idx_d       = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (num_samples_i != '0) begin
                        remaining_d = num_samples_i;
                        rd_cnt_d    = 3'd0;
                        cap_cnt_d   = 3'd0;
                        rd_pend_d   = 1'b0;
                        state_d     = ST_FETCH;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_FETCH: begin
                rd_pend_d = rd_en;
                if (rd_en) begin
                    rd_cnt_d = rd_cnt_q + 3'd1;
                end
                if (rd_pend_q) begin
                    word_d    = {word_q[23:0], fifo_data_i};
                    cap_cnt_d = cap_cnt_q + 3'd1;
                    if (cap_cnt_q == 3'd3) begin
                        state_d   = ST_EMIT;
                        idx_d     = 2'd0;
                        rd_cnt_d  = 3'd0;
                        cap_cnt_d = 3'd0;
                    end
                end
            end
            ST_EMIT: begin
                if (sample_ready_i) begin
                    remaining_d = remaining_q - COUNT_W'(1);
                    if (remaining_q == COUNT_W'(1)) begin
                        state_d = ST_DONE;
                    end else if (idx_q == 2'd2) begin
                        state_d = ST_FETCH;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            rd_cnt_q    <= 3'd0;
            cap_cnt_q   <= 3'd0;
            rd_pend_q   <= 1'b0;
            word_q      <= 32'd0;
            idx_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            rd_cnt_q    <= rd_cnt_d;
            cap_cnt_q   <= cap_cnt_d;
            rd_pend_q   <= rd_pend_d;
            word_q      <= word_d;
            idx_q       <= idx_d;
        end
    end

    always_comb begin
        sample_o = 10'd0;
        if (state_q == ST_EMIT) begin
            case (idx_q)
                2'd0:    sample_o = word_q[9:0];
                2'd1:    sample_o = word_q[19:10];
                default: sample_o = word_q[29:20];
            endcase
        end
    end

    assign fifo_rd_en_o   = rd_en;
    assign sample_valid_o = (state_q == ST_EMIT);
    assign sample_or_o    = (state_q == ST_EMIT) && word_q[31];
    assign sample_trig_o  = (state_q == ST_EMIT) && word_q[30];
    assign busy_o         = (state_q == ST_FETCH) || (state_q == ST_EMIT);
    assign done_o         = (state_q == ST_DONE);

endmodule

// File: tb/tb_adcfifo_unpack.sv
// Scoreboard bench for adcfifo_unpack: a byte-FIFO model feeds the DUT and a
// monitor compares every accepted sample against queued expectations.
module tb_adcfifo_unpack;

    logic        clk_100mhz = 1'b0;
    logic        reset_n;
    logic        start_i;
    logic [31:0] num_samples_i;
    logic        fifo_empty_i;
    logic [7:0]  fifo_data_i;
    logic        fifo_rd_en_o;
    logic [9:0]  sample_o;
    logic        sample_or_o;
    logic        sample_trig_o;
    logic        sample_valid_o;
    logic        sample_ready_i;
    logic        busy_o;
    logic        done_o;

    int npass = 0;
    int ntot  = 0;
    int reads = 0;
    int rd_viol = 0;
    int done_viol = 0;
    logic prev_done = 1'b0;

    logic [7:0] mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    logic force_empty = 1'b0;
    logic [11:0] exp_q [$];

    always #5 clk_100mhz = ~clk_100mhz;

    assign fifo_empty_i = (wr_ptr == rd_ptr) || force_empty;

    adcfifo_unpack #(.COUNT_W(32)) dut (
        .clk_100mhz     (clk_100mhz),
        .reset_n        (reset_n),
        .start_i        (start_i),
        .num_samples_i  (num_samples_i),
        .fifo_empty_i   (fifo_empty_i),
        .fifo_data_i    (fifo_data_i),
        .fifo_rd_en_o   (fifo_rd_en_o),
        .sample_o       (sample_o),
        .sample_or_o    (sample_or_o),
        .sample_trig_o  (sample_trig_o),
        .sample_valid_o (sample_valid_o),
        .sample_ready_i (sample_ready_i),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        else npass++;
    endtask

    // FIFO model: data appears the cycle after the read strobe.
    always @(posedge clk_100mhz) begin
        if (fifo_rd_en_o && !fifo_empty_i) begin
            fifo_data_i <= mem[rd_ptr % 64];
            rd_ptr <= rd_ptr + 1;
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk_100mhz) begin
        if (reset_n) begin
            if (fifo_rd_en_o) begin
                reads++;
                if (fifo_empty_i) rd_viol++;
            end
            if (sample_valid_o && sample_ready_i) begin
                if (exp_q.size() == 0) chk("unexpected_sample", 32'd1, 32'd0);
                else chk("sample", {20'd0, sample_or_o, sample_trig_o, sample_o}, {20'd0, exp_q.pop_front()});
            end
            if (done_o) chk("done_busy_low", {31'd0, busy_o}, 32'd0);
            if (done_o && prev_done) done_viol++;
            prev_done = done_o;
        end
    end

    task automatic push_byte(input logic [7:0] b);
        mem[wr_ptr % 64] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) push_byte(w[31-8*i -: 8]);
    endtask

    task automatic push_exp(input logic orf, input logic trg, input logic [9:0] s);
        exp_q.push_back({orf, trg, s});
    endtask

    task automatic start_run(input int n);
        @(posedge clk_100mhz); #1;
        num_samples_i = n;
        start_i = 1'b1;
        @(posedge clk_100mhz); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge clk_100mhz);
            if (done_o) break;
        end
        if (k == 300) chk({nm, "_timeout"}, 32'd1, 32'd0);
        @(negedge clk_100mhz);
    endtask

    task automatic wait_valid(input string nm);
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge clk_100mhz);
            if (sample_valid_o) break;
        end
        if (k == 300) chk({nm, "_valid_timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        int rb;
        reset_n = 1'b0;
        start_i = 1'b0;
        num_samples_i = 32'd0;
        sample_ready_i = 1'b1;
        fifo_data_i = 8'd0;
        #1;
        chk("reset_outputs", {24'd0, fifo_rd_en_o, sample_valid_o, busy_o, done_o,
                              sample_or_o, sample_trig_o, 2'b00}, 32'd0);
        chk("reset_sample", {22'd0, sample_o}, 32'd0);
        repeat (3) @(posedge clk_100mhz);
        #1 reset_n = 1'b1;

        // Basic word 0x40200C01.
        rb = reads;
        push_word(32'h4020_0C01);
        push_exp(1'b0, 1'b1, 10'h001);
        push_exp(1'b0, 1'b1, 10'h003);
        push_exp(1'b0, 1'b1, 10'h002);
        start_run(3);
        wait_done("t1");
        chk("t1_reads", reads - rb, 32'd4);
        chk("t1_drained", exp_q.size(), 32'd0);

        // Four samples across two words; s1/s2 of word 2 discarded.
        rb = reads;
        push_word(32'h4020_0C01);
        push_word(32'h8000_0155);
        push_exp(1'b0, 1'b1, 10'h001);
        push_exp(1'b0, 1'b1, 10'h003);
        push_exp(1'b0, 1'b1, 10'h002);
        push_exp(1'b1, 1'b0, 10'h155);
        start_run(4);
        wait_done("t2");
        chk("t2_reads", reads - rb, 32'd8);
        chk("t2_drained", exp_q.size(), 32'd0);

        // Backpressure for 5 cycles while s1 is presented.
        rb = reads;
        sample_ready_i = 1'b0;
        push_word(32'hFFFA_A955);
        push_exp(1'b1, 1'b1, 10'h155);
        push_exp(1'b1, 1'b1, 10'h2AA);
        push_exp(1'b1, 1'b1, 10'h3FF);
        start_run(3);
        wait_valid("t3");
        @(posedge clk_100mhz); #1 sample_ready_i = 1'b1;
        @(posedge clk_100mhz); #1 sample_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_100mhz);
            chk("t3_hold", {19'd0, sample_valid_o, fifo_rd_en_o, sample_or_o, sample_o},
                {19'd0, 1'b1, 1'b0, 1'b1, 10'h2AA});
        end
        @(posedge clk_100mhz); #1 sample_ready_i = 1'b1;
        wait_done("t3");
        chk("t3_reads", reads - rb, 32'd4);
        chk("t3_drained", exp_q.size(), 32'd0);

        // FIFO empty after two bytes for 10 cycles.
        rb = reads;
        push_byte(8'h12);
        push_byte(8'h34);
        push_exp(1'b0, 1'b0, 10'h278);
        push_exp(1'b0, 1'b0, 10'h115);
        push_exp(1'b0, 1'b0, 10'h123);
        start_run(3);
        repeat (3) @(negedge clk_100mhz);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_100mhz);
            chk("t4_no_read", {31'd0, fifo_rd_en_o}, 32'd0);
        end
        chk("t4_stalled_reads", reads - rb, 32'd2);
        @(posedge clk_100mhz); #1;
        push_byte(8'h56);
        push_byte(8'h78);
        wait_done("t4");
        chk("t4_reads", reads - rb, 32'd4);
        chk("t4_drained", exp_q.size(), 32'd0);

        // Zero samples: done one cycle after start, no reads.
        rb = reads;
        @(posedge clk_100mhz); #1;
        num_samples_i = 32'd0;
        start_i = 1'b1;
        @(negedge clk_100mhz);
        chk("t5_no_done_yet", {31'd0, done_o}, 32'd0);
        @(posedge clk_100mhz); #1 start_i = 1'b0;
        @(negedge clk_100mhz);
        chk("t5_done", {30'd0, done_o, busy_o}, 32'd2);
        @(negedge clk_100mhz);
        chk("t5_done_clear", {31'd0, done_o}, 32'd0);
        chk("t5_reads", reads - rb, 32'd0);

        // Start while busy must be ignored.
        rb = reads;
        sample_ready_i = 1'b0;
        push_word(32'h4020_0C01);
        push_exp(1'b0, 1'b1, 10'h001);
        push_exp(1'b0, 1'b1, 10'h003);
        push_exp(1'b0, 1'b1, 10'h002);
        start_run(3);
        @(negedge clk_100mhz);
        chk("t5_busy", {31'd0, busy_o}, 32'd1);
        start_run(6);
        wait_valid("t5b");
        @(posedge clk_100mhz); #1 sample_ready_i = 1'b1;
        wait_done("t5b");
        chk("t5b_reads", reads - rb, 32'd4);
        chk("t5b_drained", exp_q.size(), 32'd0);

        // Reset pulsed during EMIT.
        sample_ready_i = 1'b0;
        push_word(32'hFFFA_A955);
        start_run(3);
        wait_valid("t6");
        @(posedge clk_100mhz); #1 reset_n = 1'b0;
        #1;
        chk("t6_reset_outs", {22'd0, fifo_rd_en_o, sample_valid_o, busy_o, done_o,
                              sample_or_o, sample_trig_o, 4'd0}, 32'd0);
        chk("t6_reset_sample", {22'd0, sample_o}, 32'd0);
        @(posedge clk_100mhz); #1 reset_n = 1'b1;
        sample_ready_i = 1'b1;
        rb = reads;
        repeat (6) @(negedge clk_100mhz);
        chk("t6_idle", {29'd0, busy_o, sample_valid_o, fifo_rd_en_o}, 32'd0);
        chk("t6_idle_reads", reads - rb, 32'd0);
        push_word(32'h4020_0C01);
        push_exp(1'b0, 1'b1, 10'h001);
        push_exp(1'b0, 1'b1, 10'h003);
        push_exp(1'b0, 1'b1, 10'h002);
        start_run(3);
        wait_done("t6");
        chk("t6_reads", reads - rb, 32'd4);
        chk("t6_drained", exp_q.size(), 32'd0);

        chk("rd_while_empty", rd_viol, 32'd0);
        chk("done_width", done_viol, 32'd0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
